alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  Single-cycle floating-point multiply-accumulate unit for one neuron lane of the NN accelerator.
//  Each clock it multiplies INPUT_SCALER by WEIGHT_SCALER, then adds the product to the running sum or restarts the sum with it.
//  Operands and result use the 34-bit exception-tagged float: {exc[1:0], sign, exp[7:0], frac[22:0]}.
//  exc encoding: 00 zero, 01 normal, 10 infinity, 11 NaN.
// PARAMETERS
//  BIT_WIDTH   32  IEEE-754 single-precision payload width (sign+exp+frac)
//  EXTRA_BITS  2   exception-tag width prepended above the payload
// PORTS
//  CLK            in   1                     rising-edge clock
//  RESET          in   1                     asynchronous, active-high reset
//  WEIGHT_SCALER  in   BIT_WIDTH+EXTRA_BITS  weight operand w
//  INPUT_SCALER   in   BIT_WIDTH+EXTRA_BITS  input operand x
//  ACC_EN         in   1                     1: accumulate; 0: restart the sum with the current product
//  ACC_RESULT     out  BIT_WIDTH+EXTRA_BITS  registered accumulator value
// BEHAVIOUR
//  - RESET=1: ACC_RESULT <= {2'b00, 32'h0} (+0) immediately, independent of CLK. RESET has priority.
//  - Each rising CLK edge with RESET=0:
//      p = round(x*w)
//      ACC_EN=1: ACC_RESULT <= round(ACC_RESULT + p)
//      ACC_EN=0: ACC_RESULT <= p
//  - Latency: 1 cycle. The result for the operands present before edge N is visible after edge N.
//    No handshake: a new operand pair is accepted every cycle.
//  - Multiply and add are combinational within the cycle, with two roundings: product, then sum.
//  - Rounding: round-to-nearest-even on both operations. No subnormals.
//  - Multiply, normal operands:
//      sign = xor of signs; exp = ex + ew - 127; 24x24-bit mantissa product, normalised by at most 1 bit.
//  - Add, normal operands:
//      align to the larger exponent and keep guard/round/sticky; add or subtract magnitudes;
//      normalise with a leading-zero count; the result takes the sign of the larger magnitude.
//  - Underflow (biased exp <= 0 after normalisation/rounding) -> exc=00, payload 0.
//  - Overflow (exp >= 255) -> exc=10, sign kept, exp/frac = 0.
//  - Exact cancellation (a + -a) -> exc=00, sign 0.
//  - Exceptions are decided by exc bits only; the payload of non-normal inputs is ignored.
//  - Multiply exceptions:
//      NaN op -> NaN; inf*0 -> NaN; inf*(normal|inf) -> inf (xor sign); 0*(normal|0) -> zero.
//  - Add exceptions:
//      NaN -> NaN; +inf + -inf -> NaN; inf + finite -> inf; zero + b -> b.
//  - NaN output: exc=11, payload 0.
//  - ACC_RESULT is always a clean register output with no combinational path from the inputs.
//  - X on ACC_EN/operands while RESET=1 has no effect.
// STRUCTURE
//  - Shared package: exception codes (EXC_ZERO/NORMAL/INF/NAN), EXP_W=8, FRAC_W=23, BIAS=127,
//    and field-slice helper functions.
//  - One natural sub-module: fp_add (exception-tagged adder, combinational).
//  - The multiplier and the accumulator register stay inline in alu.
// TESTING  (compare payload within +/-1 ulp; exc must match exactly)
//  1. RESET=1 for 3 cycles with ACC_EN=0 -> ACC_RESULT = 0_00000000.
//     Assert RESET mid-run -> clears without a clock edge.
//  2. Release reset. ACC_EN=1, x=1.23 (3f9d70a4), w=4.56 (4091eb85), one edge -> 1_40b37b4a (5.6088).
//  3. Next edge, ACC_EN=1, x=7.89 (40fc7ae1), w=10.11 (4121c28f) -> 1_42aac0df (85.3767).
//  4. ACC_EN=0, x=1.11 (3f8e147b), w=2.22 (400e147b) -> 1_401db574 (2.4642), prior sum discarded.
//  5. ACC_EN=1, x=3.33 (40551eb8), w=4.44 (408e147b) -> 1_4189fec5 (17.2494).
//  6. Exceptions:
//      x exc=10 (inf), w exc=00 -> exc 11 (NaN);
//      x=+inf with ACC_EN=1 after a normal sum -> exc 10;
//      x=2^100, w=2^100 -> exc 10;
//      x=2^-100, w=2^-100 -> exc 00.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the exception-tagged float MAC lane:
// exception codes, field widths and slice/pack helpers.
package alu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int FLT_W  = 2 + 1 + EXP_W + FRAC_W;   // {exc, sign, exp, frac}

    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } exc_e;

    function automatic logic [1:0] f_exc(input logic [FLT_W-1:0] v);
        return v[FLT_W-1 -: 2];
    endfunction

    function automatic logic f_sign(input logic [FLT_W-1:0] v);
        return v[EXP_W+FRAC_W];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [FLT_W-1:0] v);
        return v[FRAC_W +: EXP_W];
    endfunction

    function automatic logic [FRAC_W-1:0] f_frac(input logic [FLT_W-1:0] v);
        return v[FRAC_W-1:0];
    endfunction

    function automatic logic [FLT_W-1:0] f_pack(input logic [1:0]        exc,
                                                 input logic              sign,
                                                 input logic [EXP_W-1:0]  exp,
                                                 input logic [FRAC_W-1:0] frac);
        return {exc, sign, exp, frac};
    endfunction

endpackage

// File: rtl/alu_fp_add.sv
// Combinational exception-tagged float adder, round-to-nearest-even,
// no subnormals. Special operands are resolved from the exc tag only.
module fp_add
    import alu_pkg::*;
(
    input  logic [FLT_W-1:0] a_i,
    input  logic [FLT_W-1:0] b_i,
    output logic [FLT_W-1:0] y_o
);

    logic                    a_big;
    logic                    s_big, s_sml;
    logic [EXP_W-1:0]        e_big, e_sml, d;
    logic [FRAC_W-1:0]       f_big, f_sml;
    logic [26:0]             m_big, m_sml_raw, m_sml, lost_mask;
    logic [27:0]             sum;
    logic [4:0]              lz;
    logic [26:0]             nrm;
    logic signed [9:0]       e_nrm, e_out;
    logic                    rnd_up;
    logic [24:0]             m_rnd;
    logic [FRAC_W-1:0]       f_out;
    logic [FLT_W-1:0]        y_norm;

    // Normal + normal datapath: align with G/R/S, add/sub, normalise, round.
    always_comb begin
        // Order operands by magnitude so the difference is never negative
        a_big = {f_exp(a_i), f_frac(a_i)} >= {f_exp(b_i), f_frac(b_i)};
        s_big = a_big ? f_sign(a_i) : f_sign(b_i);
        s_sml = a_big ? f_sign(b_i) : f_sign(a_i);
        e_big = a_big ? f_exp(a_i)  : f_exp(b_i);
        e_sml = a_big ? f_exp(b_i)  : f_exp(a_i);
        f_big = a_big ? f_frac(a_i) : f_frac(b_i);
        f_sml = a_big ? f_frac(b_i) : f_frac(a_i);
        d     = e_big - e_sml;

        // 24-bit mantissa plus guard, round, sticky
        m_big     = {1'b1, f_big, 3'b000};
        m_sml_raw = {1'b1, f_sml, 3'b000};
        lost_mask = '0;
        if (d >= 8'd27) begin
            // Everything shifted out; only the hidden one survives as sticky
            m_sml = 27'd1;
        end else begin
            lost_mask = ~({27{1'b1}} << d);
            m_sml     = m_sml_raw >> d;
            m_sml[0]  = m_sml[0] | (|(m_sml_raw & lost_mask));
        end

        if (s_big == s_sml) sum = {1'b0, m_big} + {1'b0, m_sml};
        else                sum = {1'b0, m_big} - {1'b0, m_sml};

        // Leading-zero count over the 27-bit magnitude (highest set bit wins)
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end

        if (sum[27]) begin
            nrm   = {sum[27:2], sum[1] | sum[0]};
            e_nrm = $signed({2'b00, e_big}) + 10'sd1;
        end else begin
            nrm   = sum[26:0] << lz;
            e_nrm = $signed({2'b00, e_big}) - $signed({5'b00000, lz});
        end

        rnd_up = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        m_rnd  = {1'b0, nrm[26:3]} + 25'(rnd_up);
        if (m_rnd[24]) begin
            f_out = m_rnd[23:1];
            e_out = e_nrm + 10'sd1;
        end else begin
            f_out = m_rnd[22:0];
            e_out = e_nrm;
        end

        if (sum == '0)
            y_norm = f_pack(EXC_ZERO, 1'b0, '0, '0);
        else if (e_out >= 10'sd255)
            y_norm = f_pack(EXC_INF, s_big, '0, '0);
        else if (e_out <= 10'sd0)
            y_norm = f_pack(EXC_ZERO, 1'b0, '0, '0);
        else
            y_norm = f_pack(EXC_NORMAL, s_big, e_out[EXP_W-1:0], f_out);
    end

    // Special-operand resolution; falls through to the normal datapath.
    always_comb begin
        y_o = y_norm;
        if (f_exc(a_i) == EXC_NAN || f_exc(b_i) == EXC_NAN)
            y_o = f_pack(EXC_NAN, 1'b0, '0, '0);
        else if (f_exc(a_i) == EXC_INF && f_exc(b_i) == EXC_INF)
            y_o = (f_sign(a_i) != f_sign(b_i)) ? f_pack(EXC_NAN, 1'b0, '0, '0)
                                               : f_pack(EXC_INF, f_sign(a_i), '0, '0);
        else if (f_exc(a_i) == EXC_INF)
            y_o = f_pack(EXC_INF, f_sign(a_i), '0, '0);
        else if (f_exc(b_i) == EXC_INF)
            y_o = f_pack(EXC_INF, f_sign(b_i), '0, '0);
        else if (f_exc(a_i) == EXC_ZERO && f_exc(b_i) == EXC_ZERO)
            y_o = f_pack(EXC_ZERO, 1'b0, '0, '0);
        else if (f_exc(a_i) == EXC_ZERO)
            y_o = b_i;
        else if (f_exc(b_i) == EXC_ZERO)
            y_o = a_i;
    end

endmodule

// File: rtl/alu.sv
// Single-cycle float multiply-accumulate lane: p = x*w, then either
// acc + p or a restart with p, registered into ACC_RESULT.
module alu
    import alu_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int EXTRA_BITS = 2
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0] WEIGHT_SCALER,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0] INPUT_SCALER,
    input  logic                            ACC_EN,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0] ACC_RESULT
);

    logic [FLT_W-1:0]  acc_q, acc_d;
    logic [FLT_W-1:0]  prod, sum;
    logic [47:0]       mant_prod;
    logic [23:0]       m_pre;
    logic              g, st, rnd_up;
    logic [24:0]       m_rnd;
    logic [FRAC_W-1:0] f_out;
    logic signed [9:0] e_pre, e_out;
    logic [FLT_W-1:0]  p_norm;
    logic [1:0]        xe, we;
    logic              p_sign;

    assign xe     = f_exc(INPUT_SCALER);
    assign we     = f_exc(WEIGHT_SCALER);
    assign p_sign = f_sign(INPUT_SCALER) ^ f_sign(WEIGHT_SCALER);

    // Normal x normal product: 24x24 mantissa multiply, 1-bit normalise, RNE.
    always_comb begin
        mant_prod = {24'b0, 1'b1, f_frac(INPUT_SCALER)} * {24'b0, 1'b1, f_frac(WEIGHT_SCALER)};
        e_pre     = $signed({2'b00, f_exp(INPUT_SCALER)}) + $signed({2'b00, f_exp(WEIGHT_SCALER)})
                    - $signed(10'(BIAS));
        if (mant_prod[47]) begin
            m_pre = mant_prod[47:24];
            g     = mant_prod[23];
            st    = |mant_prod[22:0];
            e_pre = e_pre + 10'sd1;
        end else begin
            m_pre = mant_prod[46:23];
            g     = mant_prod[22];
            st    = |mant_prod[21:0];
        end
        rnd_up = g & (st | m_pre[0]);
        m_rnd  = {1'b0, m_pre} + 25'(rnd_up);
        if (m_rnd[24]) begin
            f_out = m_rnd[23:1];
            e_out = e_pre + 10'sd1;
        end else begin
            f_out = m_rnd[22:0];
            e_out = e_pre;
        end

        if (e_out >= 10'sd255)
            p_norm = f_pack(EXC_INF, p_sign, '0, '0);
        else if (e_out <= 10'sd0)
            p_norm = f_pack(EXC_ZERO, 1'b0, '0, '0);
        else
            p_norm = f_pack(EXC_NORMAL, p_sign, e_out[EXP_W-1:0], f_out);
    end

    // Product exception resolution from the exc tags.
    always_comb begin
        prod = p_norm;
        if (xe == EXC_NAN || we == EXC_NAN)
            prod = f_pack(EXC_NAN, 1'b0, '0, '0);
        else if ((xe == EXC_INF && we == EXC_ZERO) || (xe == EXC_ZERO && we == EXC_INF))
            prod = f_pack(EXC_NAN, 1'b0, '0, '0);
        else if (xe == EXC_INF || we == EXC_INF)
            prod = f_pack(EXC_INF, p_sign, '0, '0);
        else if (xe == EXC_ZERO || we == EXC_ZERO)
            prod = f_pack(EXC_ZERO, 1'b0, '0, '0);
    end

    fp_add u_add (
        .a_i (acc_q),
        .b_i (prod),
        .y_o (sum)
    );

    // Next accumulator value: keep summing or restart with the product.
    always_comb begin
        acc_d = ACC_EN ? sum : prod;
    end

    // Accumulator register; reset clears to +0 without waiting for a clock.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign ACC_RESULT = acc_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the float MAC lane. Normal results are
// compared within +/-1 ulp of payload; exc tags must match exactly.
module tb_alu;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [33:0] WEIGHT_SCALER, INPUT_SCALER;
    logic        ACC_EN;
    logic [33:0] ACC_RESULT;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [33:0] ZERO  = {2'b00, 32'h0};
    localparam logic [33:0] P_INF = {2'b10, 32'h0};
    localparam logic [33:0] N_INF = {2'b10, 32'h80000000};
    localparam logic [33:0] NAN   = {2'b11, 32'h0};

    alu #(.BIT_WIDTH(32), .EXTRA_BITS(2)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .WEIGHT_SCALER (WEIGHT_SCALER),
        .INPUT_SCALER  (INPUT_SCALER),
        .ACC_EN        (ACC_EN),
        .ACC_RESULT    (ACC_RESULT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [33:0] nrm(input logic [31:0] v);
        return {2'b01, v};
    endfunction

    task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
        logic   ok;
        longint diff;
        n_cmp++;
        if (got[33:32] != exp[33:32]) begin
            ok = 1'b0;
        end else if (exp[33:32] == 2'b01) begin
            diff = longint'(got[31:0]) - longint'(exp[31:0]);
            ok   = (diff >= -1) && (diff <= 1);
        end else begin
            ok = (got == exp);
        end
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic [33:0] x, input logic [33:0] w);
        @(negedge CLK);
        ACC_EN        = en;
        INPUT_SCALER  = x;
        WEIGHT_SCALER = w;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET         = 1'b1;
        ACC_EN        = 1'b0;
        INPUT_SCALER  = '1;
        WEIGHT_SCALER = '1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            chk("rst", ACC_RESULT, ZERO);
        end
        RESET = 1'b0;

        step(1'b1, nrm(32'h3f9d70a4), nrm(32'h4091eb85));
        chk("mac1", ACC_RESULT, nrm(32'h40b37b4a));
        step(1'b1, nrm(32'h40fc7ae1), nrm(32'h4121c28f));
        chk("mac2", ACC_RESULT, nrm(32'h42aac0df));
        step(1'b0, nrm(32'h3f8e147b), nrm(32'h400e147b));
        chk("restart", ACC_RESULT, nrm(32'h401db574));
        step(1'b1, nrm(32'h40551eb8), nrm(32'h408e147b));
        chk("mac3", ACC_RESULT, nrm(32'h4189fec5));

        // Reset between edges must clear at once and hold across an edge
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("rst_async", ACC_RESULT, ZERO);
        @(posedge CLK);
        #1;
        chk("rst_hold", ACC_RESULT, ZERO);
        RESET = 1'b0;

        step(1'b0, P_INF, ZERO);
        chk("inf_x_zero", ACC_RESULT, NAN);
        step(1'b0, nrm(32'h3f800000), nrm(32'h40000000));
        chk("load2", ACC_RESULT, nrm(32'h40000000));
        step(1'b1, P_INF, nrm(32'h3f800000));
        chk("acc_inf", ACC_RESULT, P_INF);
        step(1'b1, N_INF, nrm(32'h3f800000));
        chk("inf_minus_inf", ACC_RESULT, NAN);
        step(1'b0, nrm(32'h71800000), nrm(32'h71800000));
        chk("mul_ovf", ACC_RESULT, P_INF);
        step(1'b0, nrm(32'h0d800000), nrm(32'h0d800000));
        chk("mul_unf", ACC_RESULT, ZERO);
        step(1'b0, nrm(32'hc0000000), nrm(32'h40400000));
        chk("neg_prod", ACC_RESULT, nrm(32'hc0c00000));
        step(1'b1, nrm(32'h40000000), nrm(32'h40400000));
        chk("cancel", ACC_RESULT, ZERO);
        step(1'b1, nrm(32'h3fc00000), nrm(32'h3fc00000));
        chk("zero_plus_b", ACC_RESULT, nrm(32'h40100000));
        step(1'b1, {2'b00, 32'h12345678}, nrm(32'h3f800000));
        chk("acc_zero_prod", ACC_RESULT, nrm(32'h40100000));
        step(1'b1, nrm(32'h0d800000), nrm(32'h3f800000));
        chk("far_align", ACC_RESULT, nrm(32'h40100000));
        step(1'b0, nrm(32'h3f800000), nrm(32'h3f800000));
        chk("load1", ACC_RESULT, nrm(32'h3f800000));
        step(1'b1, nrm(32'hbf700000), nrm(32'h3f800000));
        chk("lzc_norm", ACC_RESULT, nrm(32'h3d800000));
        step(1'b0, nrm(32'h7f000000), nrm(32'h3fc00000));
        chk("load_big", ACC_RESULT, nrm(32'h7f400000));
        step(1'b1, nrm(32'h7f000000), nrm(32'h3fc00000));
        chk("add_ovf", ACC_RESULT, P_INF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
